// File: rtl/eeg_pkg.sv
// Shared constants and FSM state encoding for the EEG mean-calculation path.
package eeg_pkg;

    localparam int EEG_DW      = 18;
    localparam int WIN_LEN_DEF = 256;

    typedef logic [2:0] mean_seq_state_t;

    localparam mean_seq_state_t ST_IDLE      = 3'd0;
    localparam mean_seq_state_t ST_CLR       = 3'd1;
    localparam mean_seq_state_t ST_ACCUM     = 3'd2;
    localparam mean_seq_state_t ST_DIV_ISSUE = 3'd3;
    localparam mean_seq_state_t ST_DIV_WAIT  = 3'd4;
    localparam mean_seq_state_t ST_HOLD      = 3'd5;

endpackage

// File: rtl/mean_seq_ctrl_if.sv
// Sample input, datapath control and mean output bundle of the mean sequencer.
interface mean_seq_ctrl_if import eeg_pkg::*; #(
    parameter int DW = EEG_DW
) ();

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_eeg;
    logic          mean_start;
    logic [DW-1:0] mean_eeg;
    logic          mean_start_div;
    logic          mean_complete;
    logic [DW-1:0] mean_value;
    logic          mean_clr;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_mean;

    modport master (
        input  s_valid, s_eeg, mean_complete, mean_value, m_ready,
        output s_ready, mean_start, mean_eeg, mean_start_div, mean_clr, m_valid, m_mean
    );

    modport slave (
        output s_valid, s_eeg, mean_complete, mean_value, m_ready,
        input  s_ready, mean_start, mean_eeg, mean_start_div, mean_clr, m_valid, m_mean
    );

endinterface

// File: rtl/mean_seq_wdog.sv
// Divider wait counter: masks the stale completion flag and flags a stuck divider.
module mean_seq_wdog #(
    parameter int DIV_MASK_CYC = 2,
    parameter int TIMEOUT_CYC  = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    output logic cmp_ok,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr)
            wait_cnt_d = '0;
        else if (run && wait_cnt_q != '1)
            wait_cnt_d = wait_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt_q <= '0;
        else
            wait_cnt_q <= wait_cnt_d;
    end

    // Timeout fires on the cycle whose increment would make the count reach TIMEOUT_CYC.
    assign cmp_ok  = (wait_cnt_q >= CW'(DIV_MASK_CYC));
    assign timeout = (wait_cnt_q >= CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mean_seq_ctrl.sv
// Window sequencer: feeds samples to the mean datapath, runs the divider and publishes the mean.
module mean_seq_ctrl import eeg_pkg::*; #(
    parameter int WIN_LEN      = WIN_LEN_DEF,
    parameter int DIV_MASK_CYC = 2,
    parameter int TIMEOUT_CYC  = 16,
    parameter int DW           = EEG_DW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             abort,
    mean_seq_ctrl_if.master  bus,
    output logic             busy,
    output logic             err_timeout
);

    localparam logic [8:0] LAST_IDX = 9'(WIN_LEN - 1);

    mean_seq_state_t state_q, state_d;
    logic [8:0]      sample_cnt_q, sample_cnt_d;
    logic            clr_go_q, clr_go_d;
    logic            m_valid_q, m_valid_d;
    logic [DW-1:0]   m_mean_q, m_mean_d;
    logic            err_q, err_d;
    logic            mean_clr_q, mean_clr_d;
    logic            en_q;

    logic s_ready, accept, cmp_ok, timeout, capture, tmo_fire;

    mean_seq_wdog #(
        .DIV_MASK_CYC (DIV_MASK_CYC),
        .TIMEOUT_CYC  (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     ((state_q != ST_DIV_WAIT) | abort),
        .run     (state_q == ST_DIV_WAIT),
        .cmp_ok  (cmp_ok),
        .timeout (timeout)
    );

    assign s_ready  = (state_q == ST_ACCUM);
    assign accept   = bus.s_valid & s_ready;
    assign capture  = (state_q == ST_DIV_WAIT) & cmp_ok & bus.mean_complete & ~abort;
    assign tmo_fire = (state_q == ST_DIV_WAIT) & timeout & ~capture & ~abort;

    // clr_go remembers whether the clear pass should start a new window or drop back to idle.
    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        clr_go_d     = clr_go_q;
        m_valid_d    = m_valid_q;
        m_mean_d     = m_mean_q;
        err_d        = err_q;

        if (state_q == ST_IDLE && en && !en_q)
            err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d  = ST_CLR;
                    clr_go_d = 1'b1;
                end
            end
            ST_CLR: begin
                sample_cnt_d = '0;
                state_d      = clr_go_q ? ST_ACCUM : ST_IDLE;
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (sample_cnt_q != 9'h1FF)
                        sample_cnt_d = sample_cnt_q + 9'd1;
                    if (sample_cnt_q == LAST_IDX)
                        state_d = ST_DIV_ISSUE;
                end
            end
            ST_DIV_ISSUE: state_d = ST_DIV_WAIT;
            ST_DIV_WAIT: begin
                if (capture) begin
                    m_mean_d  = bus.mean_value;
                    m_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (tmo_fire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    clr_go_d  = en;
                    state_d   = ST_CLR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d      = ST_IDLE;
            sample_cnt_d = '0;
            m_valid_d    = 1'b0;
            clr_go_d     = 1'b0;
        end
    end

    assign mean_clr_d = abort | tmo_fire | (state_d == ST_CLR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sample_cnt_q <= '0;
            clr_go_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            m_mean_q     <= '0;
            err_q        <= 1'b0;
            mean_clr_q   <= 1'b0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            clr_go_q     <= clr_go_d;
            m_valid_q    <= m_valid_d;
            m_mean_q     <= m_mean_d;
            err_q        <= err_d;
            mean_clr_q   <= mean_clr_d;
            en_q         <= en;
        end
    end

    assign bus.s_ready        = s_ready;
    assign bus.mean_start     = accept;
    assign bus.mean_eeg       = bus.s_eeg;
    assign bus.mean_start_div = (state_q == ST_DIV_ISSUE) & ~abort;
    assign bus.mean_clr       = mean_clr_q;
    assign bus.m_valid        = m_valid_q;
    assign bus.m_mean         = m_mean_q;
    assign busy               = (state_q != ST_IDLE);
    assign err_timeout        = err_q;

endmodule

// File: tb/tb_mean_seq_ctrl.sv
// Directed scenario bench for mean_seq_ctrl (WIN_LEN=256 main instance, WIN_LEN=2 second instance).
module tb_mean_seq_ctrl;

    localparam logic [17:0] SAMPLE = 18'h01000;

    logic clk, reset_n, en, abort, busy, err_timeout;
    logic en2, abort2, busy2, err2;
    int   pass_cnt = 0;
    int   chk_cnt  = 0;

    mean_seq_ctrl_if #(.DW(18)) bus  ();
    mean_seq_ctrl_if #(.DW(18)) bus2 ();

    mean_seq_ctrl #(.WIN_LEN(256), .DIV_MASK_CYC(2), .TIMEOUT_CYC(16), .DW(18)) u_dut (
        .clk(clk), .reset_n(reset_n), .en(en), .abort(abort),
        .bus(bus), .busy(busy), .err_timeout(err_timeout)
    );

    mean_seq_ctrl #(.WIN_LEN(2), .DIV_MASK_CYC(2), .TIMEOUT_CYC(16), .DW(18)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en(en2), .abort(abort2),
        .bus(bus2), .busy(busy2), .err_timeout(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        en = 0; abort = 0; en2 = 0; abort2 = 0;
        bus.s_valid = 0; bus.s_eeg = '0; bus.mean_complete = 0; bus.mean_value = '0; bus.m_ready = 0;
        bus2.s_valid = 0; bus2.s_eeg = '0; bus2.mean_complete = 0; bus2.mean_value = '0; bus2.m_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic enter_accum();
        en = 1'b1;
        tick();
        tick();
    endtask

    // Offers samples until n are accepted; leaves the bench just after the edge that took the last one.
    task automatic feed(input bit gaps, input int n, output int starts, output int cycles);
        starts = 0;
        cycles = 0;
        while (starts < n && cycles < 2000) begin
            bus.s_valid = gaps ? (cycles % 2 == 0) : 1'b1;
            bus.s_eeg   = SAMPLE;
            @(negedge clk);
            if (bus.mean_start === 1'b1) starts++;
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_busy: got %0b exp 0", busy); else pass_cnt++;
        chk_cnt++; if ({bus.s_ready, bus.mean_start, bus.mean_start_div, bus.mean_clr, bus.m_valid} !== 5'b0)
            $display("[TB] FAIL rst_ctrl: got %b exp 00000", {bus.s_ready, bus.mean_start, bus.mean_start_div, bus.mean_clr, bus.m_valid});
        else pass_cnt++;
        chk_cnt++; if (bus.m_mean !== 18'h0) $display("[TB] FAIL rst_mean: got %h exp 0", bus.m_mean); else pass_cnt++;
        chk_cnt++; if (err_timeout !== 1'b0) $display("[TB] FAIL rst_err: got %0b exp 0", err_timeout); else pass_cnt++;
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rst_idle_after: got %0b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_nominal();
        int starts, cycles;
        bit early;
        do_reset();
        en = 1'b1;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL nom_idle_busy: got %0b exp 0", busy); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus.mean_clr !== 1'b1) $display("[TB] FAIL nom_clr_pre: got %0b exp 1", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL nom_clr_sready: got %0b exp 0", bus.s_ready); else pass_cnt++;
        tick();
        bus.s_eeg = 18'h01234;
        @(negedge clk);
        chk_cnt++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL nom_accum_sready: got %0b exp 1", bus.s_ready); else pass_cnt++;
        chk_cnt++; if (bus.mean_eeg !== 18'h01234) $display("[TB] FAIL nom_passthru: got %h exp 01234", bus.mean_eeg); else pass_cnt++;
        chk_cnt++; if (bus.mean_start !== 1'b0) $display("[TB] FAIL nom_no_start: got %0b exp 0", bus.mean_start); else pass_cnt++;
        chk_cnt++; if (bus.mean_clr !== 1'b0) $display("[TB] FAIL nom_clr_once: got %0b exp 0", bus.mean_clr); else pass_cnt++;
        tick();
        feed(1'b0, 256, starts, cycles);
        chk_cnt++; if (starts !== 256) $display("[TB] FAIL nom_starts: got %0d exp 256", starts); else pass_cnt++;
        chk_cnt++; if (cycles !== 256) $display("[TB] FAIL nom_cycles: got %0d exp 256", cycles); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (bus.mean_start_div !== 1'b1) $display("[TB] FAIL nom_start_div: got %0b exp 1", bus.mean_start_div); else pass_cnt++;
        chk_cnt++; if (bus.mean_start !== 1'b0) $display("[TB] FAIL nom_no_257th: got %0b exp 0", bus.mean_start); else pass_cnt++;
        bus.s_valid = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.mean_complete = (k == 4);
            bus.mean_value    = 18'h0ABCD;
            @(negedge clk);
            if (k == 1) begin
                chk_cnt++; if (bus.mean_start_div !== 1'b0) $display("[TB] FAIL nom_div_pulse: got %0b exp 0", bus.mean_start_div); else pass_cnt++;
            end
            if (bus.m_valid !== 1'b0) early = 1'b1;
        end
        chk_cnt++; if (early !== 1'b0) $display("[TB] FAIL nom_early_valid: got %0b exp 0", early); else pass_cnt++;
        tick();
        bus.mean_complete = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (bus.m_valid !== 1'b1) $display("[TB] FAIL nom_mvalid: got %0b exp 1", bus.m_valid); else pass_cnt++;
        chk_cnt++; if (bus.m_mean !== 18'h0ABCD) $display("[TB] FAIL nom_mean: got %h exp 0abcd", bus.m_mean); else pass_cnt++;
        tick();
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus.m_valid !== 1'b0) $display("[TB] FAIL nom_mvalid_drop: got %0b exp 0", bus.m_valid); else pass_cnt++;
        chk_cnt++; if (bus.mean_clr !== 1'b1) $display("[TB] FAIL nom_clr_post: got %0b exp 1", bus.mean_clr); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus.s_ready !== 1'b1) $display("[TB] FAIL nom_next_window: got %0b exp 1", bus.s_ready); else pass_cnt++;
    endtask

    task automatic test_stale();
        int starts, cycles;
        do_reset();
        bus.mean_complete = 1'b1;
        bus.mean_value    = 18'h00111;
        enter_accum();
        feed(1'b0, 256, starts, cycles);
        bus.s_valid = 1'b0;
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) tick();
            if (k == 3) bus.mean_value = 18'h02222;
            @(negedge clk);
            chk_cnt++; if (bus.m_valid !== 1'b0) $display("[TB] FAIL stale_masked_t%0d: got %0b exp 0", k, bus.m_valid); else pass_cnt++;
        end
        tick();
        bus.mean_complete = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (bus.m_valid !== 1'b1) $display("[TB] FAIL stale_capture: got %0b exp 1", bus.m_valid); else pass_cnt++;
        chk_cnt++; if (bus.m_mean !== 18'h02222) $display("[TB] FAIL stale_mean: got %h exp 02222", bus.m_mean); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int starts, cycles;
        bit seen_valid;
        do_reset();
        enter_accum();
        feed(1'b0, 256, starts, cycles);
        bus.s_valid = 1'b0;
        en = 1'b0;
        seen_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            @(negedge clk);
            if (bus.m_valid !== 1'b0) seen_valid = 1'b1;
            if (k == 16) begin
                chk_cnt++; if (err_timeout !== 1'b0) $display("[TB] FAIL tmo_early: got %0b exp 0", err_timeout); else pass_cnt++;
                chk_cnt++; if (busy !== 1'b1) $display("[TB] FAIL tmo_still_wait: got %0b exp 1", busy); else pass_cnt++;
            end
        end
        tick();
        @(negedge clk);
        chk_cnt++; if (err_timeout !== 1'b1) $display("[TB] FAIL tmo_err: got %0b exp 1", err_timeout); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL tmo_idle: got %0b exp 0", busy); else pass_cnt++;
        chk_cnt++; if (bus.mean_clr !== 1'b1) $display("[TB] FAIL tmo_clr: got %0b exp 1", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if ((seen_valid | bus.m_valid) !== 1'b0) $display("[TB] FAIL tmo_no_publish: got %0b exp 0", seen_valid | bus.m_valid); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus.mean_clr !== 1'b0) $display("[TB] FAIL tmo_clr_once: got %0b exp 0", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if (err_timeout !== 1'b1) $display("[TB] FAIL tmo_sticky: got %0b exp 1", err_timeout); else pass_cnt++;
        tick();
        en = 1'b1;
        tick();
        @(negedge clk);
        chk_cnt++; if (err_timeout !== 1'b0) $display("[TB] FAIL tmo_en_clear: got %0b exp 0", err_timeout); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b1) $display("[TB] FAIL tmo_restart: got %0b exp 1", busy); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int starts, cycles;
        bit bad_hold, bad_in;
        do_reset();
        enter_accum();
        feed(1'b1, 256, starts, cycles);
        chk_cnt++; if (starts !== 256) $display("[TB] FAIL bp_starts: got %0d exp 256", starts); else pass_cnt++;
        chk_cnt++; if (cycles !== 511) $display("[TB] FAIL bp_cycles: got %0d exp 511", cycles); else pass_cnt++;
        bus.s_valid = 1'b1;
        @(negedge clk);
        chk_cnt++; if (bus.mean_start_div !== 1'b1) $display("[TB] FAIL bp_start_div: got %0b exp 1", bus.mean_start_div); else pass_cnt++;
        tick();
        tick();
        tick();
        bus.mean_complete = 1'b1;
        bus.mean_value    = 18'h03333;
        tick();
        bus.mean_complete = 1'b0;
        bad_hold = 1'b0;
        bad_in   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m_valid !== 1'b1 || bus.m_mean !== 18'h03333) bad_hold = 1'b1;
            if (bus.s_ready !== 1'b0 || bus.mean_start !== 1'b0) bad_in = 1'b1;
            tick();
        end
        chk_cnt++; if (bad_hold !== 1'b0) $display("[TB] FAIL bp_hold_stable: got %0b exp 0", bad_hold); else pass_cnt++;
        chk_cnt++; if (bad_in !== 1'b0) $display("[TB] FAIL bp_input_stalled: got %0b exp 0", bad_in); else pass_cnt++;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk_cnt++; if (bus.m_valid !== 1'b1) $display("[TB] FAIL bp_valid_at_hs: got %0b exp 1", bus.m_valid); else pass_cnt++;
        tick();
        bus.m_ready = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus.m_valid !== 1'b0) $display("[TB] FAIL bp_valid_drop: got %0b exp 0", bus.m_valid); else pass_cnt++;
        chk_cnt++; if (bus.mean_clr !== 1'b1) $display("[TB] FAIL bp_clr: got %0b exp 1", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if (bus.s_ready !== 1'b0) $display("[TB] FAIL bp_sready_clr: got %0b exp 0", bus.s_ready); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus.mean_start !== 1'b1) $display("[TB] FAIL bp_next_window: got %0b exp 1", bus.mean_start); else pass_cnt++;
        bus.s_valid = 1'b0;
    endtask

    task automatic test_abort();
        int starts, cycles;
        do_reset();
        enter_accum();
        feed(1'b0, 99, starts, cycles);
        abort = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus.mean_start !== 1'b1) $display("[TB] FAIL ab1_forward: got %0b exp 1", bus.mean_start); else pass_cnt++;
        tick();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ab1_idle: got %0b exp 0", busy); else pass_cnt++;
        chk_cnt++; if (bus.mean_clr !== 1'b1) $display("[TB] FAIL ab1_clr: got %0b exp 1", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if (bus.mean_start_div !== 1'b0) $display("[TB] FAIL ab1_no_div: got %0b exp 0", bus.mean_start_div); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus.mean_clr !== 1'b0) $display("[TB] FAIL ab1_clr_once: got %0b exp 0", bus.mean_clr); else pass_cnt++;

        enter_accum();
        feed(1'b0, 256, starts, cycles);
        bus.s_valid = 1'b0;
        tick();
        tick();
        tick();
        abort = 1'b1;
        en    = 1'b0;
        bus.mean_complete = 1'b1;
        bus.mean_value    = 18'h04444;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b1) $display("[TB] FAIL ab2_in_wait: got %0b exp 1", busy); else pass_cnt++;
        tick();
        abort = 1'b0;
        bus.mean_complete = 1'b0;
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ab2_idle: got %0b exp 0", busy); else pass_cnt++;
        chk_cnt++; if (bus.mean_clr !== 1'b1) $display("[TB] FAIL ab2_clr: got %0b exp 1", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if (bus.m_valid !== 1'b0) $display("[TB] FAIL ab2_no_valid: got %0b exp 0", bus.m_valid); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus.mean_clr !== 1'b0) $display("[TB] FAIL ab2_clr_once: got %0b exp 0", bus.mean_clr); else pass_cnt++;
        chk_cnt++; if (bus.m_valid !== 1'b0) $display("[TB] FAIL ab2_valid_late: got %0b exp 0", bus.m_valid); else pass_cnt++;

        enter_accum();
        feed(1'b0, 255, starts, cycles);
        abort = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus.mean_start !== 1'b1) $display("[TB] FAIL ab3_last_forward: got %0b exp 1", bus.mean_start); else pass_cnt++;
        tick();
        abort = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus.mean_start_div !== 1'b0) $display("[TB] FAIL ab3_no_div: got %0b exp 0", bus.mean_start_div); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ab3_idle: got %0b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_win2();
        do_reset();
        en2 = 1'b1;
        tick();
        tick();
        bus2.s_valid = 1'b1;
        bus2.s_eeg   = 18'h00010;
        @(negedge clk);
        chk_cnt++; if (bus2.mean_start !== 1'b1) $display("[TB] FAIL w2_start1: got %0b exp 1", bus2.mean_start); else pass_cnt++;
        tick();
        bus2.s_eeg = 18'h00020;
        @(negedge clk);
        chk_cnt++; if (bus2.mean_eeg !== 18'h00020) $display("[TB] FAIL w2_eeg2: got %h exp 00020", bus2.mean_eeg); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (bus2.mean_start_div !== 1'b1) $display("[TB] FAIL w2_start_div: got %0b exp 1", bus2.mean_start_div); else pass_cnt++;
        chk_cnt++; if (bus2.mean_start !== 1'b0) $display("[TB] FAIL w2_no_third: got %0b exp 0", bus2.mean_start); else pass_cnt++;
        bus2.s_valid = 1'b0;
        tick();
        tick();
        tick();
        bus2.mean_complete = 1'b1;
        bus2.mean_value    = 18'h05555;
        tick();
        bus2.mean_complete = 1'b0;
        bus2.m_ready = 1'b1;
        en2 = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus2.m_valid !== 1'b1) $display("[TB] FAIL w2_mvalid: got %0b exp 1", bus2.m_valid); else pass_cnt++;
        chk_cnt++; if (bus2.m_mean !== 18'h05555) $display("[TB] FAIL w2_mean: got %h exp 05555", bus2.m_mean); else pass_cnt++;
        tick();
        bus2.m_ready = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus2.mean_clr !== 1'b1) $display("[TB] FAIL w2_clr: got %0b exp 1", bus2.mean_clr); else pass_cnt++;
        tick();
        @(negedge clk);
        chk_cnt++; if (busy2 !== 1'b0) $display("[TB] FAIL w2_back_idle: got %0b exp 0", busy2); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        int starts, cycles;
        do_reset();
        enter_accum();
        feed(1'b0, 256, starts, cycles);
        bus.s_valid = 1'b0;
        tick();
        tick();
        tick();
        bus.mean_complete = 1'b1;
        bus.mean_value    = 18'h06666;
        tick();
        bus.mean_complete = 1'b0;
        @(negedge clk);
        chk_cnt++; if (bus.m_valid !== 1'b1) $display("[TB] FAIL ar_in_hold: got %0b exp 1", bus.m_valid); else pass_cnt++;
        #2;
        reset_n = 1'b0;
        en      = 1'b0;
        #1;
        chk_cnt++; if (bus.m_valid !== 1'b0) $display("[TB] FAIL ar_mvalid: got %0b exp 0", bus.m_valid); else pass_cnt++;
        chk_cnt++; if (bus.m_mean !== 18'h0) $display("[TB] FAIL ar_mean: got %h exp 0", bus.m_mean); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ar_busy: got %0b exp 0", busy); else pass_cnt++;
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk_cnt++; if (busy !== 1'b0) $display("[TB] FAIL ar_idle_after: got %0b exp 0", busy); else pass_cnt++;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        test_reset();
        test_nominal();
        test_stale();
        test_timeout();
        test_backpressure();
        test_abort();
        test_win2();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mean_seq_ctrl.md
Name: mean_seq_ctrl

Overview:
- Window sequencer for the EEG mean-calculation datapath.
- Accepts EEG samples over a valid/ready handshake and forwards each one to the datapath as a one-cycle start pulse.
- After WIN_LEN samples it issues the divider start, waits (with a watchdog) for divider completion, then captures the mean and presents it to the downstream feature stage over a valid/ready handshake.
- Clears the datapath between windows. Sits between the preprocessing front end and the feature-extraction FSM.

Parameters:
- WIN_LEN, 256, samples per window; legal range 2..256.
- DIV_MASK_CYC, 2, cycles after the divider start during which datapath completion is ignored. This covers the stale-high completion flag of the sequential divider.
- TIMEOUT_CYC, 16, maximum cycles in DIV_WAIT before an error abort.
- DW, 18, sample and mean width (Q1.5.12).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run enable; sampled only in IDLE and on HOLD exit
- abort  in  1  synchronous soft abort, any state
- s_valid  in  1  input sample valid
- s_ready  out  1  controller can accept a sample
- s_eeg  in  DW  input sample
- mean_start  out  1  per-sample accumulate strobe to the datapath
- mean_eeg  out  DW  sample to the datapath
- mean_start_div  out  1  one-cycle divider start to the datapath
- mean_complete  in  1  datapath divider complete
- mean_value  in  DW  datapath mean result
- mean_clr  out  1  one-cycle synchronous clear of the datapath accumulator and count
- m_valid  out  1  captured mean valid
- m_ready  in  1  downstream accepts the mean
- m_mean  out  DW  captured mean
- busy  out  1  state is not IDLE
- err_timeout  out  1  sticky divider timeout flag; cleared by reset or by en rising in IDLE

Behaviour:
- Reset values: state=IDLE, sample counter=0, wait counter=0. All outputs are 0: s_ready, mean_start, mean_start_div, mean_clr, m_valid, m_mean, busy, err_timeout.
- FSM states: IDLE, CLR, ACCUM, DIV_ISSUE, DIV_WAIT, HOLD.
- IDLE:
  - If en=1, go to CLR next cycle.
  - A 0→1 edge of en seen in IDLE also clears err_timeout.
- CLR:
  - Drive mean_clr=1 for exactly one cycle, then go to ACCUM.
  - Sample counter is set to 0.
- ACCUM:
  - s_ready=1.
  - mean_start = s_valid & s_ready, combinational.
  - mean_eeg = s_eeg, combinational pass-through, zero latency.
  - Each accepted sample increments the 9-bit sample counter.
  - On the acceptance that makes count==WIN_LEN, go to DIV_ISSUE. No further sample is accepted that cycle or after.
- DIV_ISSUE:
  - mean_start_div=1 for one cycle; s_ready=0.
  - Wait counter is set to 0; go to DIV_WAIT.
- DIV_WAIT:
  - The wait counter increments every cycle.
  - mean_complete is ignored while wait counter < DIV_MASK_CYC.
  - Otherwise, mean_complete=1 captures mean_value into m_mean, sets m_valid=1 and goes to HOLD.
  - If the wait counter reaches TIMEOUT_CYC without a valid completion: set err_timeout=1, pulse mean_clr, go to IDLE. Nothing is published.
- HOLD:
  - m_valid stays 1 and m_mean stays stable until m_ready=1.
  - On the m_valid & m_ready cycle: m_valid goes to 0 next cycle.
  - Then go to CLR if en=1, else go to CLR and then IDLE. The datapath is always cleared after a window.
  - s_ready=0 throughout HOLD, so back-pressure stalls the input.
- Window-to-window latency: last sample accepted → mean_start_div on the next cycle. Completion observed → m_valid on the next cycle.
- abort:
  - Highest priority. Next state=IDLE; mean_clr pulses for one cycle; m_valid is dropped; counters are zeroed.
  - No divider start is issued that cycle.
  - Abort in IDLE is a no-op apart from the mean_clr pulse.
- Simultaneous abort and final-sample acceptance: the sample is still forwarded (mean_start=1, combinational), but the window is discarded.
- en deasserted mid-window: the window completes normally. en is re-evaluated at HOLD exit.
- Reset mid-operation: asynchronous return to reset values. The datapath shares reset_n, so no clear is needed.
- Sample counter width is 9 bits, so WIN_LEN=256 is reachable without wrap. The counter saturates; it never wraps inside a window.
- busy = (state != IDLE).

Decomposition:
- Shared package (eeg_pkg):
  - state enum mean_seq_state_t;
  - EEG_DW=18;
  - default window length constant WIN_LEN_DEF=256.
- One natural sub-module: mean_seq_wdog. It holds the DIV_WAIT wait counter, the mask compare and the timeout compare, and outputs cmp_ok and timeout.
- Everything else stays in the top module.

Test Plan:
- Nominal window. Setup: en=1, WIN_LEN=256, 256 back-to-back samples of 0x01000; the datapath model asserts complete 4 cycles after start_div with mean_value=0x0ABCD. Required response:
  - exactly 256 mean_start pulses;
  - mean_start_div 1 cycle after the last sample;
  - m_mean=0x0ABCD, with m_valid 1 cycle after complete;
  - mean_clr pulses before and after the window.
- Stale completion. Stimulus: model holds mean_complete=1 continuously from reset, then drops it on start_div and raises it again 3 cycles later. Required response: no capture in the masked cycles; capture on the rise.
- Timeout. Stimulus: model never asserts complete. Required response: err_timeout=1 exactly TIMEOUT_CYC=16 cycles into DIV_WAIT; mean_clr pulse; return to IDLE; m_valid never 1.
- Back-pressure:
  - m_ready=0 for 20 cycles in HOLD: s_ready=0 and m_mean stable throughout; the next window starts only after the handshake.
  - Input gaps: with s_valid toggling 50%, the window closes after 256 accepted samples, not 256 cycles.
- Abort. Stimulus: abort on sample 100, then abort in DIV_WAIT. Required response: each abort gives IDLE next cycle and one mean_clr pulse, with no start_div (first case) and no m_valid. With WIN_LEN=2, a 2-sample window publishes normally.
- Async reset. Stimulus: reset_n low during HOLD. Required response: all outputs 0 immediately (asynchronous); state=IDLE after release.
